// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch sequencer states and reset PC.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t PC_RESET = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        DMEM   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Instruction addresses are word aligned; drop the byte offset.
    function automatic word_t align_word(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_request_unit_if.sv
// Bundle of the fetch/sequencing signals between caches, control unit and datapath.
interface fetch_request_unit_if
    import cpu_types_pkg::*;
(
    input logic CLK,
    input logic nRST
);
    logic  ihit;
    word_t iload;
    logic  dhit;
    logic  dREN_req;
    logic  dWEN_req;
    logic  halt_req;
    word_t next_pc;
    logic  imemREN;
    word_t imemaddr;
    logic  dmemREN;
    logic  dmemWEN;
    word_t imemload;
    word_t pc;
    word_t pc_plus4;
    logic  commit;
    logic  halt;

    modport fru (
        input  CLK, nRST, ihit, iload, dhit, dREN_req, dWEN_req, halt_req, next_pc,
        output imemREN, imemaddr, dmemREN, dmemWEN, imemload, pc, pc_plus4, commit, halt
    );

    modport tb (
        input  CLK, nRST, imemREN, imemaddr, dmemREN, dmemWEN, imemload, pc, pc_plus4,
               commit, halt,
        output ihit, iload, dhit, dREN_req, dWEN_req, halt_req, next_pc
    );
endinterface

// File: rtl/fetch_request_unit.sv
// Multicycle fetch/sequencer: owns PC and instruction register, sequences the
// data-memory access of each instruction and latches halt.
module fetch_request_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = PC_RESET
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t iload,
    input  logic  dhit,
    input  logic  dREN_req,
    input  logic  dWEN_req,
    input  logic  halt_req,
    input  word_t next_pc,
    output logic  imemREN,
    output word_t imemaddr,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t imemload,
    output word_t pc,
    output word_t pc_plus4,
    output logic  commit,
    output logic  halt
);

    fetch_state_t state_q, state_d;
    word_t        pc_d, imemload_d;
    logic         dren_d, dwen_d;

    assign imemaddr = pc;

    // Next-state, register updates and the combinational retire strobe.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        imemload_d = imemload;
        dren_d     = dmemREN;
        dwen_d     = dmemWEN;
        commit     = 1'b0;
        case (state_q)
            FETCH: begin
                if (ihit) begin
                    imemload_d = iload;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else if (dREN_req || dWEN_req) begin
                    dren_d  = dREN_req & ~dWEN_req;
                    dwen_d  = dWEN_req;
                    state_d = DMEM;
                end else begin
                    commit  = 1'b1;
                    pc_d    = align_word(next_pc);
                    state_d = FETCH;
                end
            end
            DMEM: begin
                if (dhit) begin
                    commit  = 1'b1;
                    pc_d    = align_word(next_pc);
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Request and halt flags are registered from the next state so they stay Moore.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= FETCH;
            pc       <= PC_INIT;
            pc_plus4 <= PC_INIT + 32'd4;
            imemload <= 32'h0000_0000;
            dmemREN  <= 1'b0;
            dmemWEN  <= 1'b0;
            imemREN  <= 1'b1;
            halt     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            pc_plus4 <= pc_d + 32'd4;
            imemload <= imemload_d;
            dmemREN  <= dren_d;
            dmemWEN  <= dwen_d;
            imemREN  <= (state_d == FETCH);
            halt     <= (state_d == HALTED);
        end
    end

endmodule
